// File: rtl/branch_predict_unit.sv
// EX-stage branch resolver with a PC-indexed saturating-counter predictor (bimodal or gshare).
// Define BPU_PERF_CNT_EN to add saturating resolved-branch / mispredict counters.
module branch_predict_unit #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned GSHARE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  if_pc,
    output logic             if_pred_taken,
    output logic [IDX_W-1:0] if_pred_idx,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic [2:0]       ex_funct3,
    input  logic             cf,
    input  logic             zf,
    input  logic             vf,
    input  logic             sf,
    input  logic             ex_pred_taken,
    input  logic [IDX_W-1:0] ex_pred_idx,
    output logic [1:0]       flag,
    output logic             mispredict,
    output logic [31:0]      perf_branches,
    output logic [31:0]      perf_mispred
);

    localparam int unsigned      N_ENT   = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((1 << (CNT_W - 1)) - 1);

    logic             br_taken;
    logic             f3_cond;
    logic             cond;
    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] ghr_d;
    logic [CNT_W-1:0] ctr_q [N_ENT];
    logic [CNT_W-1:0] ctr_d [N_ENT];
    logic [CNT_W-1:0] ctr_cur;
    logic             unused_pc;

    // Condition evaluation from the compare-subtraction flags
    always_comb begin
        br_taken = 1'b0;
        f3_cond  = 1'b1;
        case (ex_funct3)
            3'b000:  br_taken = zf;
            3'b001:  br_taken = ~zf;
            3'b100:  br_taken = sf ^ vf;
            3'b101:  br_taken = ~(sf ^ vf);
            3'b110:  br_taken = ~cf;
            3'b111:  br_taken = cf;
            default: f3_cond  = 1'b0;
        endcase
    end

    assign cond = ex_valid & ex_branch & ~ex_jump & f3_cond;

    always_comb begin
        flag = 2'b00;
        if (ex_valid) begin
            if (ex_branch && ex_jump) begin
                flag = 2'b01;
            end else if (!ex_branch && ex_jump) begin
                flag = 2'b10;
            end else if (cond) begin
                flag = {1'b0, br_taken};
            end
        end
    end

    assign mispredict = cond & (br_taken != ex_pred_taken);

    // Fetch-side lookup; reads registered state so a same-cycle write is not visible
    assign pc_idx        = if_pc[IDX_W+1:2];
    assign if_pred_idx   = (GSHARE != 0) ? (pc_idx ^ ghr_q) : pc_idx;
    assign if_pred_taken = ctr_q[if_pred_idx][CNT_W-1];
    assign unused_pc     = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0]};

    // Saturating training of the entry the branch was predicted from
    always_comb begin
        ctr_d   = ctr_q;
        ctr_cur = ctr_q[ex_pred_idx];
        if (cond) begin
            if (br_taken && (ctr_cur != CNT_MAX)) begin
                ctr_d[ex_pred_idx] = ctr_cur + CNT_W'(1);
            end else if (!br_taken && (ctr_cur != '0)) begin
                ctr_d[ex_pred_idx] = ctr_cur - CNT_W'(1);
            end
        end
    end

    always_comb begin
        ghr_d = ghr_q;
        if (cond) begin
            ghr_d = (ghr_q << 1) | IDX_W'(br_taken);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_ENT); i++) begin
                ctr_q[i] <= CNT_RST;
            end
            ghr_q <= '0;
        end else begin
            for (int i = 0; i < int'(N_ENT); i++) begin
                ctr_q[i] <= ctr_d[i];
            end
            ghr_q <= (GSHARE != 0) ? ghr_d : '0;
        end
    end

`ifdef BPU_PERF_CNT_EN
    logic [31:0] perf_br_q;
    logic [31:0] perf_br_d;
    logic [31:0] perf_mp_q;
    logic [31:0] perf_mp_d;

    // Event counters stick at all-ones rather than wrapping
    always_comb begin
        perf_br_d = perf_br_q;
        perf_mp_d = perf_mp_q;
        if (cond && (perf_br_q != 32'hFFFF_FFFF)) begin
            perf_br_d = perf_br_q + 32'd1;
        end
        if (mispredict && (perf_mp_q != 32'hFFFF_FFFF)) begin
            perf_mp_d = perf_mp_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            perf_br_q <= perf_br_d;
            perf_mp_q <= perf_mp_d;
        end
    end

    assign perf_branches = perf_br_q;
    assign perf_mispred  = perf_mp_q;
`else
    assign perf_branches = '0;
    assign perf_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: a bimodal and a gshare instance against an array-based reference model.
module tb_branch_predict_unit;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned IDX_W = 6;
    localparam int          N     = 64;
    localparam int          MAX_B = 3;
    localparam int          MAX_G = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic [PC_W-1:0]  if_pc;
    logic             ex_valid, ex_branch, ex_jump;
    logic [2:0]       ex_funct3;
    logic             cf, zf, vf, sf;
    logic             ex_pred_taken;
    logic [IDX_W-1:0] ex_pred_idx;

    logic             b_pt, g_pt, b_mis, g_mis;
    logic [IDX_W-1:0] b_idx, g_idx;
    logic [1:0]       b_flag, g_flag;
    logic [31:0]      b_perf_br, b_perf_mp, g_perf_br, g_perf_mp;

    int n_checks = 0;
    int n_fails  = 0;

    int      ctr_b [N];
    int      ctr_g [N];
    int      ghr_m;
    longint  perf_br_m, perf_mp_m;

    always #5 clk = ~clk;

    branch_predict_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(2), .GSHARE(0)) dut_b (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(b_pt), .if_pred_idx(b_idx),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_funct3(ex_funct3),
        .cf(cf), .zf(zf), .vf(vf), .sf(sf), .ex_pred_taken(ex_pred_taken), .ex_pred_idx(ex_pred_idx),
        .flag(b_flag), .mispredict(b_mis), .perf_branches(b_perf_br), .perf_mispred(b_perf_mp)
    );

    branch_predict_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(3), .GSHARE(1)) dut_g (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(g_pt), .if_pred_idx(g_idx),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_funct3(ex_funct3),
        .cf(cf), .zf(zf), .vf(vf), .sf(sf), .ex_pred_taken(ex_pred_taken), .ex_pred_idx(ex_pred_idx),
        .flag(g_flag), .mispredict(g_mis), .perf_branches(g_perf_br), .perf_mispred(g_perf_mp)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            ctr_b[i] = 1;
            ctr_g[i] = 3;
        end
        ghr_m     = 0;
        perf_br_m = 0;
        perf_mp_m = 0;
    endfunction

    // -1: not a conditional-branch code, else 0/1 outcome
    function automatic int resolve(input logic [2:0] f3, input logic c, z, v, s);
        case (f3)
            3'd0:    return z ? 1 : 0;
            3'd1:    return z ? 0 : 1;
            3'd4:    return (s != v) ? 1 : 0;
            3'd5:    return (s == v) ? 1 : 0;
            3'd6:    return c ? 0 : 1;
            3'd7:    return c ? 1 : 0;
            default: return -1;
        endcase
    endfunction

    function automatic int bump(input int v, input int t, input int mx);
        if (t == 1) return (v < mx) ? v + 1 : v;
        return (v > 0) ? v - 1 : v;
    endfunction

    task automatic drive(input bit v, input bit br, input bit j, input logic [2:0] f3,
                         input logic [3:0] fl, input bit pt, input int pidx, input logic [31:0] pc);
        ex_valid      = v;
        ex_branch     = br;
        ex_jump       = j;
        ex_funct3     = f3;
        {cf, zf, vf, sf} = fl;
        ex_pred_taken = pt;
        ex_pred_idx   = IDX_W'(pidx);
        if_pc         = pc;
    endtask

    // Called at a negedge with inputs driven; checks outputs, clocks once, advances the model
    task automatic step();
        int k, pi, gi, ef;
        bit is_cond, em;
        k       = resolve(ex_funct3, cf, zf, vf, sf);
        is_cond = ex_valid && ex_branch && !ex_jump && (k >= 0);
        if (!ex_valid)                   ef = 0;
        else if (ex_branch && ex_jump)   ef = 1;
        else if (!ex_branch && ex_jump)  ef = 2;
        else if (is_cond)                ef = k;
        else                             ef = 0;
        em = is_cond && (k != int'(ex_pred_taken));
        pi = int'(if_pc >> 2) % N;
        gi = pi ^ ghr_m;
        #1;
        check("flag_b", b_flag, ef);
        check("flag_g", g_flag, ef);
        check("mis_b", b_mis, em);
        check("mis_g", g_mis, em);
        check("idx_b", b_idx, pi);
        check("idx_g", g_idx, gi);
        check("pt_b", b_pt, ctr_b[pi] >= 2);
        check("pt_g", g_pt, ctr_g[gi] >= 4);
`ifdef BPU_PERF_CNT_EN
        check("perf_br", b_perf_br, perf_br_m);
        check("perf_mp", b_perf_mp, perf_mp_m);
`else
        check("perf_br_off", b_perf_br, 0);
        check("perf_mp_off", g_perf_mp, 0);
`endif
        @(posedge clk);
        if (is_cond) begin
            ctr_b[int'(ex_pred_idx)] = bump(ctr_b[int'(ex_pred_idx)], k, MAX_B);
            ctr_g[int'(ex_pred_idx)] = bump(ctr_g[int'(ex_pred_idx)], k, MAX_G);
            ghr_m = ((ghr_m << 1) | k) % N;
            if (perf_br_m < 64'hFFFF_FFFF) perf_br_m++;
        end
        if (em && perf_mp_m < 64'hFFFF_FFFF) perf_mp_m++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] pc;
        int pidx;
        rst = 1'b1;
        model_reset();
        drive(0, 0, 0, 3'd0, 4'd0, 0, 0, 32'h40);
        #3;
        check("rst_pt_b", b_pt, 0);
        check("rst_pt_g", g_pt, 0);
        check("rst_idx_g", g_idx, 16);
        check("rst_flag", b_flag, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // BEQ taken, predicted not-taken, trains idx 5 to saturation
        for (int r = 0; r < 3; r++) begin
            drive(1, 1, 0, 3'b000, 4'b0100, 0, 5, 32'd20);
            #1;
            check("beq_flag", b_flag, 2'b01);
            check("beq_mis", b_mis, 1);
            if (r == 2) check("ctr5_taken", b_pt, 1);
            step();
        end
        drive(1, 1, 0, 3'b000, 4'b0000, 1, 5, 32'd20);
        #1;
        check("ctr5_sat", b_pt, 1);
        step();
        drive(0, 0, 0, 3'd0, 4'd0, 0, 0, 32'd20);
        #1;
        check("ctr5_dec", b_pt, 1);
        step();

        // Jumps
        drive(1, 1, 1, 3'b000, 4'b0100, 0, 9, 32'd36);
        #1;
        check("jal_flag", b_flag, 2'b01);
        check("jal_mis", b_mis, 0);
        step();
        drive(1, 0, 1, 3'b000, 4'b0000, 1, 9, 32'd36);
        #1;
        check("jalr_flag", g_flag, 2'b10);
        check("jalr_mis", g_mis, 0);
        step();

        // Full funct3 x flag sweep
        for (int f = 0; f < 8; f++) begin
            for (int fl = 0; fl < 16; fl++) begin
                drive(1, 1, 0, 3'(f), 4'(fl), fl[0], 10, 32'd40);
                step();
            end
        end

        // Invalid EX slot, then write-after-read on one index
        apply_reset();
        drive(0, 1, 0, 3'b001, 4'b0000, 0, 6, 32'd24);
        #1;
        check("inv_flag", b_flag, 0);
        check("inv_mis", b_mis, 0);
        step();
        drive(1, 1, 0, 3'b001, 4'b0000, 0, 6, 32'd24);
        #1;
        check("war_old", b_pt, 0);
        step();
        drive(0, 0, 0, 3'd0, 4'd0, 0, 0, 32'd24);
        #1;
        check("war_new", b_pt, 1);
        step();

        // Global history T,T,N then async reset mid-cycle
        apply_reset();
        drive(1, 1, 0, 3'b000, 4'b0100, 0, 0, 32'd0);
        step();
        step();
        drive(1, 1, 0, 3'b000, 4'b0000, 0, 0, 32'd0);
        step();
        drive(0, 0, 0, 3'd0, 4'd0, 0, 0, 32'd0);
        #1;
        check("ghr_110", g_idx, 6);
        check("ctr0_taken", b_pt, 1);
        if_pc = 32'h7C;
        #1;
        check("gidx_xor", g_idx, 31 ^ 6);
        if_pc = 32'd0;
        rst = 1'b1;
        #1;
        check("rst_ghr", g_idx, 0);
        check("rst_ctr", b_pt, 0);
        rst = 1'b0;
        model_reset();
        step();

`ifdef BPU_PERF_CNT_EN
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 3'b000, 4'b0100, (i < 3) ? 1'b0 : 1'b1, 12, 32'd0);
            step();
        end
        drive(0, 0, 0, 3'd0, 4'd0, 0, 0, 32'd0);
        #1;
        check("perf10", b_perf_br, 10);
        check("perf3", b_perf_mp, 3);
        step();
`endif

        // Randomised traffic over a small index range so counters saturate
        apply_reset();
        for (int n = 0; n < 1500; n++) begin
            pidx = $urandom_range(0, 7);
            pc   = $urandom();
            pc[7:2] = ($urandom_range(0, 1) == 1) ? 6'(pidx) : 6'($urandom_range(0, 7));
            drive(($urandom_range(0, 4) != 0), 1'($urandom()), ($urandom_range(0, 3) == 0),
                  3'($urandom()), 4'($urandom()), 1'($urandom()), pidx, pc);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
